// File: rtl/rggen_host_if_axi4lite_arb.sv
// rggen_host_if_axi4lite_arb: AXI4-Lite slave to rggen local-bus bridge, one access in flight, with arbitration, DECERR and timeout
// ports: clk/rst_n; AXI4-Lite AW/W/B/AR/R channels (i_*/o_*, prot ignored);
//        local bus o_command_valid/o_write/o_read/o_address/o_write_data/o_write_mask, i_response_ready/i_read_data/i_status
module rggen_host_if_axi4lite_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int HOST_ADDRESS_WIDTH = 16,
  parameter int LOCAL_ADDRESS_WIDTH = 16,
  parameter int ARBITRATION = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_awvalid,
  output logic                          o_awready,
  input  logic [HOST_ADDRESS_WIDTH-1:0] i_awaddr,
  input  logic [2:0]                    i_awprot,
  input  logic                          i_wvalid,
  output logic                          o_wready,
  input  logic [DATA_WIDTH-1:0]         i_wdata,
  input  logic [DATA_WIDTH/8-1:0]       i_wstrb,
  output logic                          o_bvalid,
  input  logic                          i_bready,
  output logic [1:0]                    o_bresp,
  input  logic                          i_arvalid,
  output logic                          o_arready,
  input  logic [HOST_ADDRESS_WIDTH-1:0] i_araddr,
  input  logic [2:0]                    i_arprot,
  output logic                          o_rvalid,
  input  logic                          i_rready,
  output logic [DATA_WIDTH-1:0]         o_rdata,
  output logic [1:0]                    o_rresp,
  output logic                          o_command_valid,
  output logic                          o_write,
  output logic                          o_read,
  output logic [LOCAL_ADDRESS_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0]         o_write_data,
  output logic [DATA_WIDTH-1:0]         o_write_mask,
  input  logic                          i_response_ready,
  input  logic [DATA_WIDTH-1:0]         i_read_data,
  input  logic [1:0]                    i_status
);
  localparam int DW = DATA_WIDTH;
  localparam int LAW = LOCAL_ADDRESS_WIDTH;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
  typedef enum logic [2:0] {IDLE, WAIT_W, WAIT_AW, WR_BUSY, WAIT_B, RD_BUSY, WAIT_R} state_e;
  state_e r_state;
  logic r_command_valid, r_rr_last, r_decerr, r_bvalid, r_rvalid;
  logic [LAW-1:0] r_address;
  logic [DW-1:0] r_write_data, r_write_mask, r_rdata;
  logic [1:0] r_bresp, r_rresp;
  logic [TW-1:0] r_tcnt;
  logic w_idle, w_wr_req, w_wr_ok, w_rd_ok, w_aw_hs, w_w_hs, w_ar_hs;
  logic w_aw_decerr, w_ar_decerr, w_done, w_timeout, w_finish, w_unused;
  logic [1:0] w_resp;
  logic [DW-1:0] w_mask;
  assign w_unused = ^{i_awprot, i_arprot};
  for (genvar b = 0; b < DW / 8; b++) begin : g_mask
    assign w_mask[8*b+:8] = {8{i_wstrb[b]}};
  end
  assign w_idle = r_state == IDLE;
  assign w_wr_req = i_awvalid | i_wvalid;
  // r_rr_last = 1 means read was granted last, so a tie goes to write
  assign w_wr_ok = ARBITRATION == 1 ? !i_arvalid : ARBITRATION == 2 ? (!i_arvalid | r_rr_last) : 1'b1;
  assign w_rd_ok = ARBITRATION == 0 ? !w_wr_req : ARBITRATION == 2 ? (!w_wr_req | !r_rr_last) : 1'b1;
  assign o_awready = (w_idle & i_awvalid & w_wr_ok) | (r_state == WAIT_AW);
  assign o_wready = (w_idle & i_wvalid & w_wr_ok) | (r_state == WAIT_W);
  assign o_arready = w_idle & i_arvalid & w_rd_ok;
  assign w_aw_hs = i_awvalid & o_awready;
  assign w_w_hs = i_wvalid & o_wready;
  assign w_ar_hs = i_arvalid & o_arready;
  assign w_aw_decerr = |(i_awaddr >> LAW);
  assign w_ar_decerr = |(i_araddr >> LAW);
  assign w_done = r_command_valid & i_response_ready;
  assign w_timeout = TIMEOUT_CYCLES != 0 && r_command_valid && !i_response_ready && int'(r_tcnt) == TIMEOUT_CYCLES - 1;
  assign w_finish = r_decerr | w_done | w_timeout;
  assign w_resp = r_decerr ? 2'b11 : !w_done ? 2'b10 : i_status[0] ? 2'b10 : i_status[1] ? 2'b01 : 2'b00;
  assign o_command_valid = r_command_valid;
  assign o_write = r_state == WR_BUSY;
  assign o_read = r_state == RD_BUSY;
  assign o_address = r_address;
  assign o_write_data = r_write_data;
  assign o_write_mask = r_write_mask;
  assign o_bvalid = r_bvalid;
  assign o_bresp = r_bresp;
  assign o_rvalid = r_rvalid;
  assign o_rresp = r_rresp;
  assign o_rdata = r_rdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_rr_last <= 1'b1;
      r_command_valid <= 1'b0;
      r_decerr <= 1'b0;
      r_address <= '0;
      r_write_data <= '0;
      r_write_mask <= '0;
      r_tcnt <= '0;
      r_bvalid <= 1'b0;
      r_bresp <= 2'b00;
      r_rvalid <= 1'b0;
      r_rresp <= 2'b00;
      r_rdata <= '0;
    end else begin
      if (w_aw_hs) begin
        r_address <= i_awaddr[LAW-1:0];
        r_decerr <= w_aw_decerr;
      end
      if (w_ar_hs) begin
        r_address <= i_araddr[LAW-1:0];
        r_decerr <= w_ar_decerr;
      end
      if (w_w_hs) begin
        r_write_data <= i_wdata;
        r_write_mask <= w_mask;
      end
      if (w_idle && (w_aw_hs || w_w_hs)) r_rr_last <= 1'b0;
      if (w_ar_hs) r_rr_last <= 1'b1;
      r_tcnt <= !r_command_valid ? '0 : !i_response_ready ? r_tcnt + 1'b1 : r_tcnt;
      case (r_state)
        IDLE: begin
          if (w_aw_hs && w_w_hs) begin
            r_state <= WR_BUSY;
            r_command_valid <= !w_aw_decerr;
          end else if (w_aw_hs) begin
            r_state <= WAIT_W;
          end else if (w_w_hs) begin
            r_state <= WAIT_AW;
          end else if (w_ar_hs) begin
            r_state <= RD_BUSY;
            r_command_valid <= !w_ar_decerr;
          end
        end
        WAIT_W: if (w_w_hs) begin
          r_state <= WR_BUSY;
          r_command_valid <= !r_decerr;
        end
        WAIT_AW: if (w_aw_hs) begin
          r_state <= WR_BUSY;
          r_command_valid <= !w_aw_decerr;
        end
        WR_BUSY, RD_BUSY: if (w_finish) begin
          r_state <= r_state == WR_BUSY ? WAIT_B : WAIT_R;
          r_command_valid <= 1'b0;
          r_decerr <= 1'b0;
          r_address <= '0;
          r_write_data <= '0;
          r_write_mask <= '0;
          if (r_state == WR_BUSY) begin
            r_bvalid <= 1'b1;
            r_bresp <= w_resp;
          end else begin
            r_rvalid <= 1'b1;
            r_rresp <= w_resp;
            r_rdata <= w_done ? i_read_data : '0;
          end
        end
        WAIT_B: if (i_bready) begin
          r_state <= IDLE;
          r_bvalid <= 1'b0;
          r_bresp <= 2'b00;
        end
        WAIT_R: if (i_rready) begin
          r_state <= IDLE;
          r_rvalid <= 1'b0;
          r_rresp <= 2'b00;
          r_rdata <= '0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rggen_host_if_axi4lite_arb.sv
// tb_rggen_host_if_axi4lite_arb: directed plus random checks of the AXI4-Lite bridge (dut 0 round-robin, dut 1 write priority)
module tb_rggen_host_if_axi4lite_arb;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic awvalid [2], awready [2], wvalid [2], wready [2], bvalid [2], bready [2];
  logic arvalid [2], arready [2], rvalid [2], rready [2];
  logic cmd_valid [2], lwrite [2], lread [2], resp_ready [2];
  logic [19:0] awaddr [2], araddr [2];
  logic [31:0] wdata [2], rdata [2], wr_data [2], wr_mask [2], read_data [2];
  logic [3:0] wstrb [2];
  logic [1:0] bresp [2], rresp [2], status [2];
  logic [15:0] laddr [2];
  int total = 0;
  int bad = 0;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    rggen_host_if_axi4lite_arb #(
      .DATA_WIDTH(32), .HOST_ADDRESS_WIDTH(20), .LOCAL_ADDRESS_WIDTH(16),
      .ARBITRATION(g == 0 ? 2 : 0), .TIMEOUT_CYCLES(TO)
    ) u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_awvalid(awvalid[g]), .o_awready(awready[g]), .i_awaddr(awaddr[g]), .i_awprot(3'b000),
      .i_wvalid(wvalid[g]), .o_wready(wready[g]), .i_wdata(wdata[g]), .i_wstrb(wstrb[g]),
      .o_bvalid(bvalid[g]), .i_bready(bready[g]), .o_bresp(bresp[g]),
      .i_arvalid(arvalid[g]), .o_arready(arready[g]), .i_araddr(araddr[g]), .i_arprot(3'b000),
      .o_rvalid(rvalid[g]), .i_rready(rready[g]), .o_rdata(rdata[g]), .o_rresp(rresp[g]),
      .o_command_valid(cmd_valid[g]), .o_write(lwrite[g]), .o_read(lread[g]), .o_address(laddr[g]),
      .o_write_data(wr_data[g]), .o_write_mask(wr_mask[g]),
      .i_response_ready(resp_ready[g]), .i_read_data(read_data[g]), .i_status(status[g])
    );
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_write(input int d, input logic [19:0] a, input logic [31:0] wd, input logic [3:0] st, input int lead);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int aw_start = lead > 0 ? lead : 0;
    int w_start = lead < 0 ? -lead : 0;
    awaddr[d] = a;
    wdata[d] = wd;
    wstrb[d] = st;
    while (!(aw_done && w_done) && cyc < 20) begin
      awvalid[d] = !aw_done && cyc >= aw_start;
      wvalid[d] = !w_done && cyc >= w_start;
      #1;
      aw_hs = awvalid[d] && awready[d];
      w_hs = wvalid[d] && wready[d];
      @(negedge clk);
      aw_done |= aw_hs;
      w_done |= w_hs;
      cyc++;
    end
    awvalid[d] = 1'b0;
    wvalid[d] = 1'b0;
    chk("wr_accept_cycles", cyc, (aw_start > w_start ? aw_start : w_start) + 1);
  endtask
  task automatic send_read(input int d, input logic [19:0] a);
    int cyc = 0;
    bit hs = 0;
    araddr[d] = a;
    while (!hs && cyc < 20) begin
      arvalid[d] = 1'b1;
      #1;
      hs = arready[d];
      @(negedge clk);
      cyc++;
    end
    arvalid[d] = 1'b0;
    chk("rd_accept_cycles", cyc, 1);
  endtask
  // Local-bus side and response channel, checked against the transaction-level expectation.
  task automatic finish(input int d, input bit is_wr, input logic [19:0] a, input logic [31:0] wd, input logic [31:0] msk,
                        input int rdelay, input logic [1:0] st, input logic [31:0] rd, input int hold);
    bit dec = a >= 20'h10000;
    bit tmo = !dec && rdelay >= TO;
    int n = dec ? 1 : tmo ? TO : rdelay + 1;
    logic [1:0] exp_resp = dec ? 2'b11 : tmo ? 2'b10 : st[0] ? 2'b10 : st[1] ? 2'b01 : 2'b00;
    logic [31:0] exp_rd = (dec || tmo || is_wr) ? 32'h0 : rd;
    chk("cmd_valid_rise", cmd_valid[d], !dec);
    chk("cmd_type", {lwrite[d], lread[d]}, {is_wr, !is_wr});
    chk("no_early_resp", {bvalid[d], rvalid[d]}, 2'b00);
    if (!dec) begin
      chk("cmd_addr", laddr[d], a[15:0]);
      chk("cmd_wdata", wr_data[d], is_wr ? wd : 32'h0);
      chk("cmd_mask", wr_mask[d], is_wr ? msk : 32'h0);
    end
    for (int i = 0; i < n; i++) begin
      if (i > 0) chk("cmd_valid_hold", cmd_valid[d], 1'b1);
      if (!dec && !tmo && i == rdelay) begin
        resp_ready[d] = 1'b1;
        status[d] = st;
        read_data[d] = rd;
      end
      @(negedge clk);
      resp_ready[d] = 1'b0;
      status[d] = 2'($urandom);
      read_data[d] = $urandom;
    end
    chk("cmd_valid_drop", cmd_valid[d], 1'b0);
    chk("cmd_clear_addr", laddr[d], 16'h0);
    chk("cmd_clear_mask", wr_mask[d], 32'h0);
    chk("other_valid", is_wr ? rvalid[d] : bvalid[d], 1'b0);
    for (int i = 0; i <= hold; i++) begin
      if (is_wr) begin
        chk("bvalid", bvalid[d], 1'b1);
        chk("bresp", bresp[d], exp_resp);
      end else begin
        chk("rvalid", rvalid[d], 1'b1);
        chk("rresp", rresp[d], exp_resp);
        chk("rdata", rdata[d], exp_rd);
      end
      if (i == hold) begin
        bready[d] = is_wr;
        rready[d] = !is_wr;
      end
      @(negedge clk);
    end
    bready[d] = 1'b0;
    rready[d] = 1'b0;
    chk("resp_done", is_wr ? {bvalid[d], bresp[d]} : {rvalid[d], rresp[d]}, 3'b000);
    if (!is_wr) chk("rdata_clear", rdata[d], 32'h0);
  endtask
  task automatic txn(input int d, input bit is_wr, input logic [19:0] a, input logic [31:0] wd, input logic [3:0] strb,
                     input int lead, input int rdelay, input logic [1:0] st, input logic [31:0] rd, input int hold);
    logic [31:0] msk = 32'h0;
    for (int b = 0; b < 4; b++) if (strb[b]) msk[8*b+:8] = 8'hFF;
    if (is_wr) send_write(d, a, wd, strb, lead);
    else send_read(d, a);
    finish(d, is_wr, a, wd, msk, rdelay, st, rd, hold);
  endtask
  task automatic tie(input int d, input bit exp_wr);
    awaddr[d] = 20'h00020;
    wdata[d] = 32'hCAFE0000 + d;
    wstrb[d] = 4'hF;
    araddr[d] = 20'h00024;
    awvalid[d] = 1'b1;
    wvalid[d] = 1'b1;
    arvalid[d] = 1'b1;
    #1;
    chk("tie_awready", awready[d], exp_wr);
    chk("tie_wready", wready[d], exp_wr);
    chk("tie_arready", arready[d], !exp_wr);
    @(negedge clk);
    awvalid[d] = 1'b0;
    wvalid[d] = 1'b0;
    arvalid[d] = 1'b0;
    finish(d, exp_wr, exp_wr ? 20'h00020 : 20'h00024, 32'hCAFE0000 + d, 32'hFFFFFFFF, 1, 2'b00, 32'h5555AAAA, 0);
  endtask
  initial begin
    for (int d = 0; d < 2; d++) begin
      awvalid[d] = 0; wvalid[d] = 0; arvalid[d] = 0; bready[d] = 0; rready[d] = 0; resp_ready[d] = 0;
      awaddr[d] = 0; araddr[d] = 0; wdata[d] = 0; wstrb[d] = 0; read_data[d] = 0; status[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_valids", {bvalid[d], rvalid[d], cmd_valid[d], lwrite[d], lread[d]}, 5'b0);
      chk("rst_readies", {awready[d], wready[d], arready[d]}, 3'b0);
      chk("rst_resp", {bresp[d], rresp[d], rdata[d]}, 36'h0);
      chk("rst_cmd", {laddr[d], wr_data[d]}, 48'h0);
      chk("rst_mask", wr_mask[d], 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tie(0, 1'b1);
    tie(0, 1'b0);
    tie(1, 1'b1);
    tie(1, 1'b1);
    txn(0, 1'b1, 20'h00010, 32'hA5A5A5A5, 4'b0011, 0, 2, 2'b00, 32'h0, 1);
    txn(0, 1'b1, 20'h00004, 32'h11223344, 4'hF, 2, 0, 2'b00, 32'h0, 0);
    txn(1, 1'b1, 20'h00008, 32'h99887766, 4'b1010, -3, 1, 2'b00, 32'h0, 2);
    txn(0, 1'b0, 20'h00008, 32'h0, 4'h0, 0, 1, 2'b01, 32'h12345678, 3);
    txn(1, 1'b0, 20'h0000C, 32'h0, 4'h0, 0, 0, 2'b10, 32'hDEADBEEF, 0);
    txn(1, 1'b1, 20'h0000C, 32'h01020304, 4'b0100, 0, 0, 2'b11, 32'h0, 0);
    txn(0, 1'b0, 20'h10000, 32'h0, 4'h0, 0, 0, 2'b00, 32'hFFFF0000, 1);
    txn(0, 1'b1, 20'hF0004, 32'h77777777, 4'hF, 1, 0, 2'b00, 32'h0, 0);
    txn(0, 1'b1, 20'h00040, 32'h0BADF00D, 4'hF, 0, 20, 2'b00, 32'h0, 1);
    txn(0, 1'b1, 20'h00044, 32'h600DF00D, 4'hF, 0, TO - 1, 2'b10, 32'h0, 0);
    txn(1, 1'b0, 20'h00048, 32'h0, 4'h0, 0, TO, 2'b00, 32'h13579BDF, 0);
    txn(1, 1'b0, 20'h0004C, 32'h0, 4'h0, 0, 0, 2'b00, 32'h2468ACE0, 0);
    for (int k = 0; k < 150; k++) begin
      int d = int'($urandom_range(0, 1));
      bit is_wr = 1'($urandom);
      logic [19:0] a = ($urandom_range(0, 7) == 0) ? 20'($urandom_range(20'h10000, 20'hFFFFF)) : 20'($urandom_range(0, 16'hFFFF));
      int lead = int'($urandom_range(0, 6)) - 3;
      int rdelay = int'($urandom_range(0, 10));
      int hold = int'($urandom_range(0, 3));
      txn(d, is_wr, a, $urandom, 4'($urandom), lead, rdelay, 2'($urandom), $urandom, hold);
    end
    send_write(0, 20'h00050, 32'hABCD0123, 4'hF, 0);
    chk("mid_cmd_valid", cmd_valid[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cmd", {cmd_valid[0], lwrite[0]}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_no_b", {bvalid[0], cmd_valid[0]}, 2'b00);
    end
    txn(0, 1'b0, 20'h00054, 32'h0, 4'h0, 0, 2, 2'b00, 32'h0F0F0F0F, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
